// File: rtl/probe_pkg.sv
// Shared types and helpers for the probe capture controller.
package probe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DRAIN
  } state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/probe_capture_ctrl_if.sv
// Control, probe-input and readout stream bundle of probe_capture_ctrl.
interface probe_capture_ctrl_if #(
  parameter int unsigned SIG_BITS   = 8,
  parameter int unsigned TIME_BITS  = 32,
  parameter int unsigned DECIM_BITS = 8
);

  logic                  arm;
  logic [DECIM_BITS-1:0] decim;
  logic [SIG_BITS-1:0]   trig_level;
  logic [TIME_BITS-1:0]  time_curr;
  logic [SIG_BITS-1:0]   sig;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [TIME_BITS-1:0]  rd_time;
  logic [SIG_BITS-1:0]   rd_sig;
  logic                  rd_last;
  logic                  busy;
  logic                  done;

  modport master (
    output arm, decim, trig_level, time_curr, sig, rd_ready,
    input  rd_valid, rd_time, rd_sig, rd_last, busy, done
  );

  modport slave (
    input  arm, decim, trig_level, time_curr, sig, rd_ready,
    output rd_valid, rd_time, rd_sig, rd_last, busy, done
  );

endinterface

// File: rtl/probe_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
module probe_ram
  import probe_pkg::*;
#(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/probe_capture_ctrl.sv
// Triggered, decimated probe capture into a circular buffer with oldest-first stream readout.
// Optional macro PROBE_FORCE_TRIG_EN adds a force_trig input usable while waiting for trigger.
module probe_capture_ctrl
  import probe_pkg::*;
#(
  parameter int unsigned SIG_BITS   = 8,
  parameter int unsigned TIME_BITS  = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned PRE_TRIG   = 64,
  parameter int unsigned DECIM_BITS = 8
) (
  input logic clk,
  input logic rst,
`ifdef PROBE_FORCE_TRIG_EN
  input logic force_trig,
`endif
  probe_capture_ctrl_if.slave io
);

  localparam int unsigned PW       = ptr_width(DEPTH);
  localparam int unsigned POST_LEN = DEPTH - PRE_TRIG - 1;
  localparam int unsigned EW       = TIME_BITS + SIG_BITS;
  localparam logic [PW:0] RD_TOTAL = (PW+1)'(DEPTH);
  localparam logic [PW:0] RD_LASTI = (PW+1)'(DEPTH - 1);

  typedef struct packed {
    logic [TIME_BITS-1:0] t;
    logic [SIG_BITS-1:0]  s;
  } entry_t;

  state_e                      state_q;
  logic [DECIM_BITS-1:0]       decim_q, dcnt_q;
  logic signed [SIG_BITS-1:0]  lvl_q, prev_q;
  logic                        have_prev_q;
  logic [PW-1:0]               wr_ptr_q, pre_cnt_q, post_cnt_q;
  logic [PW:0]                 rd_cnt_q;
  logic                        p1_valid_q, p1_last_q;
  logic                        out_valid_q, out_last_q, sk_valid_q, sk_last_q;
  entry_t                      out_q, sk_q;
  logic                        busy_q, done_q;

  logic          sampling, strobe, trig_hit, re, pop;
  logic [1:0]    occ;
  logic [PW-1:0] raddr;
  entry_t        wdata, rdata;

  always_comb begin
    sampling = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
    strobe   = sampling && (dcnt_q == '0);
    trig_hit = have_prev_q && (prev_q < lvl_q) && ($signed(io.sig) >= lvl_q);
`ifdef PROBE_FORCE_TRIG_EN
    trig_hit = trig_hit || force_trig;
`endif
    wdata = '{t: io.time_curr, s: io.sig};
    pop   = out_valid_q && io.rd_ready;
    // Entries already owed to out/skid after this edge; a new read is only
    // issued if it is guaranteed a slot even if the consumer stalls next cycle.
    occ   = 2'(out_valid_q) + 2'(sk_valid_q) + 2'(p1_valid_q) - 2'(pop);
    re    = (state_q == DRAIN) && (rd_cnt_q < RD_TOTAL) && (occ <= 2'd1);
    raddr = wr_ptr_q + rd_cnt_q[PW-1:0];
  end

  probe_ram #(.WIDTH(EW), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (strobe),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      decim_q     <= '0;
      dcnt_q      <= '0;
      lvl_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      p1_valid_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sk_valid_q  <= 1'b0;
      sk_last_q   <= 1'b0;
      out_q       <= '0;
      sk_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (strobe) begin
        dcnt_q      <= decim_q;
        wr_ptr_q    <= wr_ptr_q + PW'(1);
        prev_q      <= $signed(io.sig);
        have_prev_q <= 1'b1;
      end else if (sampling) begin
        dcnt_q <= dcnt_q - DECIM_BITS'(1);
      end

      p1_valid_q <= re;
      p1_last_q  <= re && (rd_cnt_q == RD_LASTI);
      if (re) rd_cnt_q <= rd_cnt_q + (PW+1)'(1);

      // Output register holds the oldest entry, skid the next; RAM data
      // lands in whichever is free so order is preserved under stalls.
      if (out_valid_q && !pop) begin
        if (!sk_valid_q) begin
          sk_valid_q <= p1_valid_q;
          sk_last_q  <= p1_last_q;
          sk_q       <= rdata;
        end
      end else if (sk_valid_q) begin
        out_valid_q <= 1'b1;
        out_last_q  <= sk_last_q;
        out_q       <= sk_q;
        sk_valid_q  <= p1_valid_q;
        sk_last_q   <= p1_last_q;
        sk_q        <= rdata;
      end else begin
        out_valid_q <= p1_valid_q;
        out_last_q  <= p1_last_q;
        if (p1_valid_q) out_q <= rdata;
      end

      case (state_q)
        IDLE: begin
          if (io.arm) begin
            decim_q     <= io.decim;
            lvl_q       <= $signed(io.trig_level);
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            dcnt_q      <= '0;
            have_prev_q <= 1'b0;
            rd_cnt_q    <= '0;
            busy_q      <= 1'b1;
            state_q     <= PRE;
          end
        end
        PRE: begin
          if (strobe) begin
            pre_cnt_q <= pre_cnt_q + PW'(1);
            if (pre_cnt_q == PW'(PRE_TRIG - 1)) state_q <= WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          if (strobe && trig_hit) begin
            post_cnt_q <= PW'(POST_LEN);
            state_q    <= (POST_LEN == 0) ? DRAIN : POST;
          end
        end
        POST: begin
          if (strobe) begin
            post_cnt_q <= post_cnt_q - PW'(1);
            if (post_cnt_q == PW'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.rd_valid = out_valid_q;
  assign io.rd_time  = out_q.t;
  assign io.rd_sig   = out_q.s;
  assign io.rd_last  = out_last_q;
  assign io.busy     = busy_q;
  assign io.done     = done_q;

endmodule

// File: tb/tb_probe_capture_ctrl.sv
// Scoreboard bench for probe_capture_ctrl (DEPTH=16, PRE_TRIG=4); force tests need PROBE_FORCE_TRIG_EN.
module tb_probe_capture_ctrl;

  localparam int unsigned SB    = 8;
  localparam int unsigned TB    = 32;
  localparam int unsigned DB    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PRE   = 4;
  localparam int          POSTN = DEPTH - PRE - 1;

  typedef struct {
    logic [31:0] t;
    logic [7:0]  s;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  probe_capture_ctrl_if #(.SIG_BITS(SB), .TIME_BITS(TB), .DECIM_BITS(DB)) bus ();

`ifdef PROBE_FORCE_TRIG_EN
  logic force_trig = 1'b0;
`endif

  probe_capture_ctrl #(
    .SIG_BITS   (SB),
    .TIME_BITS  (TB),
    .DEPTH      (DEPTH),
    .PRE_TRIG   (PRE),
    .DECIM_BITS (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef PROBE_FORCE_TRIG_EN
    .force_trig (force_trig),
`endif
    .io         (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ca;
  exp_t        sb[$];
  logic [31:0] st[$];
  logic [7:0]  ss[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Sample pattern by sample index: 0 = ramp -8..7, 1 = crossing inside PRE, 2 = constant 5.
  function automatic logic [7:0] pat(input int mode, input int k);
    if (mode == 0) return 8'((k % 16) - 8);
    if (mode == 1) begin
      case (k)
        0: return 8'hFB;
        1: return 8'hFD;
        2: return 8'h02;
        3: return 8'h03;
        4: return 8'h04;
        5: return 8'hFE;
        6: return 8'h01;
        default: return 8'(k);
      endcase
    end
    return 8'd5;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  64'(bus.busy),     64'd0);
    check({tag, "_valid"}, 64'(bus.rd_valid), 64'd0);
    check({tag, "_done"},  64'(bus.done),     64'd0);
    check({tag, "_last"},  64'(bus.rd_last),  64'd0);
    check({tag, "_time"},  64'(bus.rd_time),  64'd0);
    check({tag, "_sig"},   64'(bus.rd_sig),   64'd0);
  endtask

  task automatic run_capture(input int mode, input int d, input logic [7:0] lvl,
                             input int rmode, input int force_k);
    int kt, cl, acc, done_seen;
    logic [31:0] ht;
    logic [7:0]  hs;
    logic        stalled;
    st.delete(); ss.delete(); sb.delete();
    bus.rd_ready   = 1'b0;
    bus.decim      = 8'(d);
    bus.trig_level = lvl;
    bus.arm        = 1'b1;
    ca = cyc;
    tick();
    bus.arm = 1'b0;
    kt = -1;
    cl = -1;
    for (int n = 0; n < 600 && cl < 0; n++) begin
      int ph, k;
      ph = cyc - ca - 1;
      k  = ph / (d + 1);
      bus.time_curr = 32'(1000 + cyc);
      bus.sig       = pat(mode, k);
`ifdef PROBE_FORCE_TRIG_EN
      force_trig = (ph % (d + 1) == 0) && (k == force_k || k == 1);
`endif
      if (ph % (d + 1) == 0) begin
        st.push_back(bus.time_curr);
        ss.push_back(bus.sig);
        if (kt < 0 && k >= int'(PRE) &&
            (($signed(ss[k-1]) < $signed(lvl) && $signed(ss[k]) >= $signed(lvl)) || k == force_k))
          kt = k;
        if (kt >= 0 && k == kt + POSTN) begin
          cl = cyc;
          for (int j = kt - int'(PRE); j <= k; j++) sb.push_back('{st[j], ss[j], (j == k)});
        end
      end
      if (cl < 0) tick();
    end
`ifdef PROBE_FORCE_TRIG_EN
    force_trig = 1'b0;
`endif
    if (cl < 0) begin
      check("trig_timeout", 64'd0, 64'd1);
      rst = 1'b1; tick(); rst = 1'b0; tick();
      return;
    end

    tick();
    for (int n = 0; n < 12 && !bus.rd_valid; n++) tick();
    check("first_valid_lat", 64'(cyc - cl), 64'd3);

    acc = 0;
    done_seen = 0;
    stalled = 1'b0;
    ht = '0;
    hs = '0;
    for (int n = 0; n < 400 && sb.size() > 0; n++) begin
      exp_t e;
      if (stalled) begin
        check("stall_valid", 64'(bus.rd_valid), 64'd1);
        check("stall_time",  64'(bus.rd_time),  64'(ht));
        check("stall_sig",   64'(bus.rd_sig),   64'(hs));
      end
      if (bus.done) done_seen++;
      bus.rd_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bus.rd_valid && bus.rd_ready) begin
        e = sb.pop_front();
        check("rd_time", 64'(bus.rd_time), 64'(e.t));
        check("rd_sig",  64'(bus.rd_sig),  64'(e.s));
        check("rd_last", 64'(bus.rd_last), 64'(e.last));
        acc++;
      end
      stalled = bus.rd_valid && !bus.rd_ready;
      ht = bus.rd_time;
      hs = bus.rd_sig;
      tick();
    end
    check("entries",      64'(acc),       64'(DEPTH));
    check("early_done",   64'(done_seen), 64'd0);
    check("done_pulse",   64'(bus.done),  64'd1);
    check("busy_cleared", 64'(bus.busy),  64'd0);
    tick();
    check("done_single",  64'(bus.done),     64'd0);
    check("valid_idle",   64'(bus.rd_valid), 64'd0);
  endtask

  initial begin
    bus.arm        = 1'b0;
    bus.decim      = '0;
    bus.trig_level = '0;
    bus.time_curr  = '0;
    bus.sig        = '0;
    bus.rd_ready   = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    run_capture(0, 0, 8'd0, 0, -1);
    run_capture(0, 3, 8'd0, 0, -1);
    run_capture(1, 0, 8'd0, 0, -1);
    run_capture(0, 1, 8'd0, 1, -1);

    bus.decim      = '0;
    bus.trig_level = '0;
    bus.arm        = 1'b1;
    ca = cyc;
    tick();
    bus.arm = 1'b0;
    for (int n = 0; n < 11; n++) begin
      bus.time_curr = 32'(1000 + cyc);
      bus.sig       = pat(0, cyc - ca - 1);
      tick();
    end
    check("busy_in_post", 64'(bus.busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_busy",  64'(bus.busy),     64'd0);
    check("rst_valid", 64'(bus.rd_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check_reset("midrst");
    run_capture(0, 2, 8'd0, 1, -1);

`ifdef PROBE_FORCE_TRIG_EN
    run_capture(2, 0, 8'd0, 0, 6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/probe_capture_ctrl.md
Name: probe_capture_ctrl

Overview:
Sequencer that wraps the time/signal probe path with a triggered capture. Samples (time_curr, sig) into a circular buffer at a programmable decimation rate and holds a fixed pre-trigger window. After a level-crossing trigger it captures the post-trigger window, then drains the buffer oldest-first over a valid/ready stream to the host readout logic.

Parameters:
SIG_BITS, 8, width of signed signal sample
TIME_BITS, 32, width of unsigned time stamp
DEPTH, 256, buffer entries; power of two, >= 4
PRE_TRIG, 64, entries kept before trigger; 1 <= PRE_TRIG <= DEPTH-1
DECIM_BITS, 8, width of decimation control

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
arm  in  1  one-cycle pulse; starts capture from IDLE
decim  in  DECIM_BITS  sample every decim+1 cycles; sampled at arm
trig_level  in  SIG_BITS  signed trigger threshold; sampled at arm
time_curr  in  TIME_BITS  current emulation time
sig  in  SIG_BITS  signed probed signal
rd_valid  out  1  readout entry valid
rd_ready  in  1  consumer accepts entry
rd_time  out  TIME_BITS  readout time stamp
rd_sig  out  SIG_BITS  readout signal
rd_last  out  1  final entry of capture
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last entry accepted

Behaviour:
- Reset (async): state IDLE; rd_valid, rd_last, done, busy = 0; rd_time, rd_sig = 0; pointers, counters = 0.
- States: IDLE -> PRE -> WAIT_TRIG -> POST -> DRAIN -> IDLE.
- IDLE: arm=1 latches decim, trig_level; clears wr_ptr, sample count, decim counter -> PRE. arm outside IDLE ignored.
- Sample strobe: decim counter = 0 on cycle after arm; strobe when counter == 0, then reload to latched decim; else decrement. Counter runs in PRE, WAIT_TRIG, POST only.
- On strobe: write {time_curr, sig} at wr_ptr; wr_ptr += 1 modulo DEPTH (wraps freely).
- PRE: after PRE_TRIG strobes -> WAIT_TRIG. Triggers ignored in PRE.
- Trigger: evaluated on strobe only; prev_sig < trig_level && sig >= trig_level (signed compare). prev_sig = sig at previous strobe; first strobe after arm never triggers.
- WAIT_TRIG: triggering sample is written; post counter loads DEPTH-PRE_TRIG-1 -> POST. If DEPTH-PRE_TRIG-1 == 0, go directly to DRAIN.
- POST: each strobe writes and decrements post counter; at 0 -> DRAIN. Buffer then holds exactly PRE_TRIG entries before trigger, trigger entry, remainder after.
- DRAIN: rd_ptr starts at wr_ptr (oldest entry); DEPTH entries output in write order. RAM read latency 1 cycle; first rd_valid 2 cycles after entering DRAIN. Output register plus one-entry skid: rd_valid/rd_time/rd_sig stable while rd_valid && !rd_ready; sustained 1 entry/cycle with rd_ready held high.
- rd_last = 1 with the DEPTH-th entry only. Handshake rd_valid && rd_ready && rd_last -> done = 1 next cycle, state IDLE.
- Capture timing: inputs not registered before write; written time equals time_curr on the strobe cycle.
- Reset mid-operation discards capture; RAM contents are don't-care.

Optional Feature:
PROBE_FORCE_TRIG_EN
- Defined: extra input port force_trig (1 bit). In WAIT_TRIG, force_trig=1 on a strobe cycle forces a trigger on that sample regardless of level. force_trig in PRE is ignored and not remembered.
- Undefined: port absent; only the level trigger exists.

Decomposition:
- probe_pkg: state enum (IDLE, PRE, WAIT_TRIG, POST, DRAIN); localparam function for pointer width, clog2(DEPTH); entry struct {time, sig} parameterized through widths passed at instantiation.
- Sub-module probe_ram: simple dual-port RAM, 1 write port, 1 registered read port, width TIME_BITS+SIG_BITS, depth DEPTH; infers block RAM.

Test Plan:
- DEPTH=16, PRE_TRIG=4, decim=0, sig ramps -8..+7 repeating, trig_level=0 -> entries 0..15 read out; entry index 4 has sig=0 with prev -1; rd_last only on entry 15; done pulses once.
- decim=3 -> consecutive rd_time values differ by exactly 4.
- Crossing occurs during PRE (third sample) -> ignored; capture triggers on next crossing after PRE completes.
- rd_ready toggles 1,0,0,1 pseudo-randomly -> no entry dropped or duplicated; outputs stable while stalled.
- Assert rst in POST -> busy=0, rd_valid=0 immediately; new arm then completes a normal capture.
- PROBE_FORCE_TRIG_EN, sig constant 5, trig_level=0, force_trig pulse in WAIT_TRIG -> capture completes; entry PRE_TRIG is the forced sample.
